// File: rtl/rf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the two writeback request channels and the register-file write port
// driven by rf_write_arbiter.
//   pipe_valid/addr/data -> pipeline writeback request, pipe_ready <- grant
//   lu_valid/addr/data   -> long-latency unit request,   lu_ready   <- grant
//   we/wb_addr/wb_data/wb_src <- registered register-file write port
//   fwd_valid            <- in-flight write visible for bypass (== we)
//   starve_cnt           <- long-latency starvation count (debug)
// Modports: master = requesters / register file side, slave = arbiter.
// -----------------------------------------------------------------------------
interface rf_write_arbiter_if #(
    parameter int CW = 4
);
    logic          pipe_valid;
    logic [4:0]    pipe_addr;
    logic [31:0]   pipe_data;
    logic          pipe_ready;

    logic          lu_valid;
    logic [4:0]    lu_addr;
    logic [31:0]   lu_data;
    logic          lu_ready;

    logic          we;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          wb_src;
    logic          fwd_valid;
    logic [CW-1:0] starve_cnt;

    modport master (
        output pipe_valid, pipe_addr, pipe_data,
        output lu_valid, lu_addr, lu_data,
        input  pipe_ready, lu_ready,
        input  we, wb_addr, wb_data, wb_src, fwd_valid, starve_cnt
    );

    modport slave (
        input  pipe_valid, pipe_addr, pipe_data,
        input  lu_valid, lu_addr, lu_data,
        output pipe_ready, lu_ready,
        output we, wb_addr, wb_data, wb_src, fwd_valid, starve_cnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between the in-order pipeline
// writeback and the long-latency unit writeback. The pipeline normally wins;
// a saturating starvation counter forces a long-latency grant after
// STARVE_LIMIT consecutive refused cycles. Accepted writes are registered and
// presented on the write port one cycle later; writes to x0 complete the
// handshake but never raise we.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-low reset
//   bus      - rf_write_arbiter_if.slave (requests, grants, write port, debug)
// Parameters:
//   STARVE_LIMIT - refused cycles before forced lu priority (1..15)
//   CW           - starvation counter width, must hold STARVE_LIMIT; must
//                  match the CW of the connected interface
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CW           = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    rf_write_arbiter_if.slave  bus
);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic          r_we;
    logic [4:0]    r_wb_addr;
    logic [31:0]   r_wb_data;
    logic          r_wb_src;
    logic [CW-1:0] r_starve_cnt;

    logic          w_force_lu;
    logic          w_pipe_ready;
    logic          w_lu_ready;
    logic          w_pipe_acc;
    logic          w_lu_acc;
    logic [4:0]    w_win_addr;
    logic [31:0]   w_win_data;
    logic [CW-1:0] w_cnt_next;

    // Readies depend only on the other source's valid, never their own, and
    // are gated low while reset is asserted. With both valid, exactly one of
    // the two readies is high, so at most one source is accepted per cycle.
    assign w_force_lu   = (r_starve_cnt == LIMIT);
    assign w_pipe_ready = i_reset & ~(bus.lu_valid & w_force_lu);
    assign w_lu_ready   = i_reset & (~bus.pipe_valid | w_force_lu);
    assign w_pipe_acc   = bus.pipe_valid & w_pipe_ready;
    assign w_lu_acc     = bus.lu_valid & w_lu_ready;

    assign w_win_addr = w_lu_acc ? bus.lu_addr : bus.pipe_addr;
    assign w_win_data = w_lu_acc ? bus.lu_data : bus.pipe_data;

    // Clear on acceptance or when lu is idle; otherwise lu was refused and
    // the count saturates at the limit.
    always_comb begin
        w_cnt_next = r_starve_cnt;
        if (!bus.lu_valid || w_lu_acc) begin
            w_cnt_next = '0;
        end else if (r_starve_cnt != LIMIT) begin
            w_cnt_next = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_we         <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_wb_src     <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_cnt_next;
            if (w_pipe_acc || w_lu_acc) begin
                r_we      <= (w_win_addr != 5'd0);
                r_wb_addr <= w_win_addr;
                r_wb_data <= w_win_data;
                r_wb_src  <= w_lu_acc;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.pipe_ready = w_pipe_ready;
    assign bus.lu_ready   = w_lu_ready;
    assign bus.we         = r_we;
    assign bus.wb_addr    = r_wb_addr;
    assign bus.wb_data    = r_wb_data;
    assign bus.wb_src     = r_wb_src;
    assign bus.fwd_valid  = r_we;
    assign bus.starve_cnt = r_starve_cnt;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed vectors for rf_write_arbiter with STARVE_LIMIT = 3. Each table row
// is one clock cycle: inputs are driven after the falling edge, readies are
// compared mid-cycle, and registered outputs plus the starvation count are
// compared just after the following rising edge. Reset behaviour is covered
// by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.CW(4)) bus ();

    rf_write_arbiter #(.STARVE_LIMIT(3), .CW(4)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_pr;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_src;
        logic [3:0]  e_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bus.pipe_valid = pv;
        bus.pipe_addr  = pa;
        bus.pipe_data  = pd;
        bus.lu_valid   = lv;
        bus.lu_addr    = la;
        bus.lu_data    = ld;
    endtask

    initial begin
        //           pv  pa     pd            lv  la    ld            pr  lr  we  addr  data          src cnt
        vecs[0]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 0, 5'd0,  32'h0,        0, 4'd0}; // idle
        vecs[1]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 0, 1, 5'd5,  32'hDEADBEEF, 0, 4'd0}; // single pipe
        vecs[2]  = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 0, 5'd5,  32'hDEADBEEF, 0, 4'd0}; // hold
        vecs[3]  = '{1, 5'd1,  32'h11,       0, 5'd0, 32'h0,        1, 0, 1, 5'd1,  32'h11,       0, 4'd0}; // back-to-back
        vecs[4]  = '{1, 5'd2,  32'h22,       0, 5'd0, 32'h0,        1, 0, 1, 5'd2,  32'h22,       0, 4'd0};
        vecs[5]  = '{1, 5'd3,  32'h33,       0, 5'd0, 32'h0,        1, 0, 1, 5'd3,  32'h33,       0, 4'd0};
        vecs[6]  = '{1, 5'd10, 32'hAAAA,     1, 5'd7, 32'h1234,     1, 0, 1, 5'd10, 32'hAAAA,     0, 4'd1}; // starve
        vecs[7]  = '{1, 5'd11, 32'hBBBB,     1, 5'd7, 32'h1234,     1, 0, 1, 5'd11, 32'hBBBB,     0, 4'd2};
        vecs[8]  = '{1, 5'd12, 32'hCCCC,     1, 5'd7, 32'h1234,     1, 0, 1, 5'd12, 32'hCCCC,     0, 4'd3};
        vecs[9]  = '{1, 5'd13, 32'hDDDD,     1, 5'd7, 32'h1234,     0, 1, 1, 5'd7,  32'h1234,     1, 4'd0}; // forced lu
        vecs[10] = '{1, 5'd13, 32'hDDDD,     0, 5'd0, 32'h0,        1, 0, 1, 5'd13, 32'hDDDD,     0, 4'd0}; // held pipe
        vecs[11] = '{0, 5'd0,  32'h0,        1, 5'd0, 32'hFFFFFFFF, 1, 1, 0, 5'd0,  32'hFFFFFFFF, 1, 4'd0}; // x0 write
        vecs[12] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 0, 5'd0,  32'hFFFFFFFF, 1, 4'd0};
        vecs[13] = '{1, 5'd20, 32'h20,       1, 5'd8, 32'h88,       1, 0, 1, 5'd20, 32'h20,       0, 4'd1}; // lu alone
        vecs[14] = '{1, 5'd21, 32'h21,       1, 5'd8, 32'h88,       1, 0, 1, 5'd21, 32'h21,       0, 4'd2};
        vecs[15] = '{0, 5'd0,  32'h0,        1, 5'd8, 32'h88,       1, 1, 1, 5'd8,  32'h88,       1, 4'd0};
        vecs[16] = '{1, 5'd22, 32'h22,       1, 5'd9, 32'h99,       1, 0, 1, 5'd22, 32'h22,       0, 4'd1}; // lu withdraws
        vecs[17] = '{1, 5'd23, 32'h23,       0, 5'd0, 32'h0,        1, 0, 1, 5'd23, 32'h23,       0, 4'd0};
        vecs[18] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 0, 5'd23, 32'h23,       0, 4'd0};

        // Reset asserted from time 0, with requests pending
        drive(1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
        #2;
        chk("rst_pr",   32'(bus.pipe_ready), 32'd0);
        chk("rst_lr",   32'(bus.lu_ready),   32'd0);
        chk("rst_we",   32'(bus.we),         32'd0);
        chk("rst_addr", 32'(bus.wb_addr),    32'd0);
        chk("rst_data", bus.wb_data,         32'd0);
        chk("rst_src",  32'(bus.wb_src),     32'd0);
        chk("rst_cnt",  32'(bus.starve_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_we", 32'(bus.we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
            #2;
            chk($sformatf("v%0d_pipe_ready", i), 32'(bus.pipe_ready), 32'(vecs[i].e_pr));
            chk($sformatf("v%0d_lu_ready", i),   32'(bus.lu_ready),   32'(vecs[i].e_lr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i),        32'(bus.we),         32'(vecs[i].e_we));
            chk($sformatf("v%0d_fwd_valid", i), 32'(bus.fwd_valid),  32'(vecs[i].e_we));
            chk($sformatf("v%0d_wb_addr", i),   32'(bus.wb_addr),    32'(vecs[i].e_addr));
            chk($sformatf("v%0d_wb_data", i),   bus.wb_data,         vecs[i].e_data);
            chk($sformatf("v%0d_wb_src", i),    32'(bus.wb_src),     32'(vecs[i].e_src));
            chk($sformatf("v%0d_starve_cnt", i), 32'(bus.starve_cnt), 32'(vecs[i].e_cnt));
        end

        // Reset mid-flight: pipe write to x9 accepted while lu is refused
        @(negedge clk);
        drive(1, 5'd9, 32'h99999999, 1, 5'd2, 32'h2222);
        @(posedge clk);
        #1;
        chk("mf_we",   32'(bus.we),         32'd1);
        chk("mf_addr", 32'(bus.wb_addr),    32'd9);
        chk("mf_cnt",  32'(bus.starve_cnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mf_rst_we",   32'(bus.we),         32'd0);
        chk("mf_rst_fwd",  32'(bus.fwd_valid),  32'd0);
        chk("mf_rst_addr", 32'(bus.wb_addr),    32'd0);
        chk("mf_rst_data", bus.wb_data,         32'd0);
        chk("mf_rst_cnt",  32'(bus.starve_cnt), 32'd0);
        chk("mf_rst_pr",   32'(bus.pipe_ready), 32'd0);
        chk("mf_rst_lr",   32'(bus.lu_ready),   32'd0);
        @(posedge clk);
        #1;
        chk("mf_rst_edge_we", 32'(bus.we), 32'd0);

        // Release with no requests: nothing is written
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        chk("rel_pr", 32'(bus.pipe_ready), 32'd1);
        chk("rel_lr", 32'(bus.lu_ready),   32'd1);
        @(posedge clk);
        #1;
        chk("rel_we", 32'(bus.we), 32'd0);

        // Acceptance right after release
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        drive(1, 5'd3, 32'h3, 0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_we",   32'(bus.we),      32'd1);
        chk("first_addr", 32'(bus.wb_addr), 32'd3);
        chk("first_data", bus.wb_data,      32'h3);

        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("first_end_we", 32'(bus.we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
